if_prefetch_queue: RTL and testbench

Instruction prefetch queue between the instruction memory port and the pipeline's IF stage. It issues sequential fetch requests over a req/ready/valid handshake and buffers up to DEPTH returned instructions with their PCs. It presents the oldest instruction to IF, which consumes it under IFWrite control. On a taken branch or jump, it flushes all buffered and in-flight instructions and restarts fetch at the redirect target.

---
 rtl/if_prefetch_queue_if.sv | 32 +++
 rtl/if_prefetch_queue.sv | 141 ++++++++++++++
 tb/tb_if_prefetch_queue.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_queue_if.sv
// Purpose : bundles the fetch-memory port and the IF-stage port of the prefetch queue.
// Latency : wiring only; no logic.
// Backpressure : imem_ready stalls a request; the queue stops issuing when its entries are all spoken for.
// Ports (master = prefetch queue, slave = memory + pipeline side):
//   imem_req/imem_addr    request to instruction memory, accepted when imem_ready=1
//   imem_valid/imem_rdata one response per accepted request
//   redirect/redirect_pc  flush and restart fetch at a new PC
//   deq                   IF consumes the head entry
//   inst_valid/inst_out/inst_pc  head entry presented to IF
interface if_prefetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        deq;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
      input  imem_ready, imem_valid, imem_rdata, redirect, redirect_pc, deq
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
      output imem_ready, imem_valid, imem_rdata, redirect, redirect_pc, deq
   );
endinterface

// File: rtl/if_prefetch_queue.sv
// Purpose : instruction prefetch queue; issues sequential word fetches and buffers DEPTH {pc, inst} entries for IF.
// Latency : response sampled at edge M is the head from the cycle after M (no bypass); one request in flight at a time.
// Backpressure : a request is only issued while count + outstanding < DEPTH; imem_ready=0 holds the request stable.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low; clears FSM, pointers, count and fetch PC
//   bus    if_prefetch_queue_if.master (memory request/response, redirect, deq, head entry)
module if_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   if_prefetch_queue_if.master bus
);

   localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // REQ: request on the bus. WAIT: accepted, response will be kept.
   // DROP: accepted before a redirect, response will be thrown away.
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          imem_req_q, imem_req_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_enq;
   logic          do_deq;

   logic [31:0]   ent_pc_q   [DEPTH];
   logic [31:0]   ent_inst_q [DEPTH];

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      imem_req_d = imem_req_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      do_enq     = 1'b0;
      do_deq     = 1'b0;

      if (bus.redirect) begin
         // Flush wins over everything, including a same-cycle deq or response.
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
         imem_req_d = 1'b0;
         case (state_q)
            // An unaccepted request is simply retracted; an accepted one
            // still owes us a response that must be swallowed.
            S_REQ:          state_d = bus.imem_ready ? S_DROP : S_IDLE;
            S_WAIT, S_DROP: state_d = bus.imem_valid ? S_IDLE : S_DROP;
            default:        state_d = S_IDLE;
         endcase
      end else begin
         do_deq = bus.deq && (count_q != '0);
         case (state_q)
            S_IDLE: begin
               if (count_q < FULL) begin
                  state_d    = S_REQ;
                  imem_req_d = 1'b1;
               end
            end
            S_REQ: begin
               if (bus.imem_ready) begin
                  state_d    = S_WAIT;
                  imem_req_d = 1'b0;
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
            S_WAIT: begin
               if (bus.imem_valid) begin
                  do_enq  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_DROP: begin
               if (bus.imem_valid) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase

         rd_ptr_d = rd_ptr_q + AW'(do_deq);
         wr_ptr_d = wr_ptr_q + AW'(do_enq);
         count_d  = count_q + CW'(do_enq) - CW'(do_deq);

         // Take the IDLE decision early on the response edge so the next
         // request goes out in the very next cycle when there is room.
         if ((state_q == S_WAIT) && bus.imem_valid && (count_d < FULL)) begin
            state_d    = S_REQ;
            imem_req_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         imem_req_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         imem_req_q <= imem_req_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entry storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         ent_pc_q[wr_ptr_q]   <= req_pc_q;
         ent_inst_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = fetch_pc_q;
   assign bus.inst_valid = (count_q != '0);
   assign bus.inst_out   = ent_inst_q[rd_ptr_q];
   assign bus.inst_pc    = ent_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Purpose : self-checking bench for if_prefetch_queue with a queue-level reference model and a latency-programmable memory.
// Latency : memory answers lat cycles after acceptance; checks sample on the falling edge.
// Backpressure : imem_ready randomised by percentage; deq driven per scenario.
module tb_if_prefetch_queue;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   if_prefetch_queue_if bus();

   if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   // reference model: FIFO contents, fetch PC, outstanding/drop flags
   ent_t        mq[$];
   logic [31:0] m_fetch_pc = RESET_PC;
   logic [31:0] m_req_pc = '0;
   bit          m_out = 0;
   bit          m_drop = 0;

   // memory model
   bit          mp_pend = 0;
   int          mp_cnt = 0;
   logic [31:0] mp_addr = '0;
   int          lat = 1;
   int          rdy_pct = 100;

   // per-edge observations
   bit          e_rst, e_acc, e_issue_bad, e_hold_bad;
   logic [31:0] e_addr, e_exp;
   bit          hold_pend = 0;
   logic [31:0] hold_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Advance one clock: capture pre-edge values, update model and memory at
   // the edge, drive memory outputs at the following falling edge.
   task automatic step();
      bit p_rst, p_req, p_rdy, p_vld, p_redir, p_deq;
      logic [31:0] p_addr, p_rpc;
      ent_t e;
      p_rst   = (reset === 1'b1);
      p_req   = (bus.imem_req === 1'b1);
      p_addr  = bus.imem_addr;
      p_rdy   = (bus.imem_ready === 1'b1);
      p_vld   = (bus.imem_valid === 1'b1);
      p_redir = (bus.redirect === 1'b1);
      p_rpc   = bus.redirect_pc;
      p_deq   = (bus.deq === 1'b1);
      e_rst       = p_rst;
      e_hold_bad  = hold_pend && (!p_req || (p_addr !== hold_addr));
      hold_pend   = p_rst && p_req && !p_rdy && !p_redir;
      hold_addr   = p_addr;
      e_issue_bad = p_rst && p_req && (m_out || (mq.size() >= DEPTH));
      e_acc       = p_rst && p_req && p_rdy;
      e_addr      = p_addr;
      e_exp       = m_fetch_pc;
      @(posedge clk);
      if (!p_rst) begin
         mq.delete();
         m_fetch_pc = RESET_PC;
         m_out = 0;
         m_drop = 0;
         mp_pend = 0;
      end else begin
         if (p_redir) begin
            mq.delete();
            m_fetch_pc = p_rpc & 32'hFFFF_FFFC;
            if (e_acc) begin
               m_out = 1;
               m_drop = 1;
            end else if (p_vld) begin
               m_out = 0;
               m_drop = 0;
            end else if (m_out) begin
               m_drop = 1;
            end
         end else begin
            if (p_deq && (mq.size() > 0)) void'(mq.pop_front());
            if (p_vld) begin
               if (!m_drop) begin
                  e.pc = m_req_pc;
                  e.inst = mem_word(m_req_pc);
                  mq.push_back(e);
               end
               m_out = 0;
               m_drop = 0;
            end
            if (e_acc) begin
               m_out = 1;
               m_req_pc = m_fetch_pc;
               m_fetch_pc = m_fetch_pc + 32'd4;
            end
         end
         if (p_vld) mp_pend = 0;
         if (e_acc) begin
            mp_pend = 1;
            mp_cnt = lat - 1;
            mp_addr = p_addr;
         end else if (mp_pend && (mp_cnt > 0)) begin
            mp_cnt--;
         end
      end
      @(negedge clk);
      bus.imem_valid = mp_pend && (mp_cnt == 0);
      bus.imem_rdata = bus.imem_valid ? mem_word(mp_addr) : $urandom;
      bus.imem_ready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.deq = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      n_cmp++;
      if (bus.imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req: got %b want 0", bus.imem_req);
      end
      n_cmp++;
      if (bus.inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid);
      end
      reset = 1'b1;
      step();
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
         n_fail++;
         $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
      end
   endtask

   task automatic test_fill();
      logic [31:0] accs[$];
      logic [31:0] want;
      lat = 1;
      rdy_pct = 100;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         step();
         if (e_acc) accs.push_back(e_addr);
      end
      n_cmp++;
      if (accs.size() != 4) begin
         n_fail++;
         $display("FAIL fill_req_count: got %0d want 4", accs.size());
      end
      for (int i = 0; i < accs.size() && i < 4; i++) begin
         want = 32'(4 * i);
         n_cmp++;
         if (accs[i] !== want) begin
            n_fail++;
            $display("FAIL fill_addr[%0d]: got %h want %h", i, accs[i], want);
         end
      end
      n_cmp++;
      if (bus.imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_req_stops: got %b want 0", bus.imem_req);
      end
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_out !== mem_word(32'h0)) begin
         n_fail++;
         $display("FAIL fill_head: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                  bus.inst_valid, bus.inst_pc, bus.inst_out, mem_word(32'h0));
      end
   endtask

   task automatic test_drain();
      logic [31:0] pcs[$];
      logic [31:0] want;
      lat = 2;
      rdy_pct = 100;
      do_reset();
      bus.deq = 1'b1;
      for (int i = 0; i < 80; i++) begin
         step();
         n_cmp++;
         if (bus.inst_valid !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL drain_valid: got %b want %b", bus.inst_valid, mq.size() != 0);
         end
         if (mq.size() != 0) begin
            n_cmp++;
            if (bus.inst_pc !== mq[0].pc || bus.inst_out !== mq[0].inst) begin
               n_fail++;
               $display("FAIL drain_head: got pc=%h inst=%h want pc=%h inst=%h",
                        bus.inst_pc, bus.inst_out, mq[0].pc, mq[0].inst);
            end
         end
         if (bus.inst_valid === 1'b1) pcs.push_back(bus.inst_pc);
      end
      n_cmp++;
      if (pcs.size() < 12) begin
         n_fail++;
         $display("FAIL drain_count: got %0d want >=12", pcs.size());
      end
      for (int i = 0; i < pcs.size(); i++) begin
         want = 32'(4 * i);
         n_cmp++;
         if (pcs[i] !== want) begin
            n_fail++;
            $display("FAIL drain_seq[%0d]: got %h want %h", i, pcs[i], want);
         end
      end
   endtask

   task automatic test_redirect_wait();
      bit found = 0;
      lat = 3;
      rdy_pct = 100;
      do_reset();
      bus.deq = 1'b1;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (e_acc && e_addr == 32'h10) found = 1;
      end
      n_cmp++;
      if (!found) begin
         n_fail++;
         $display("FAIL rw_reach_0x10: got no accept of 00000010 want one within 200 cycles");
      end
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h100;
      step();
      bus.redirect = 1'b0;
      n_cmp++;
      if (bus.inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_flush: got inst_valid=%b want 0", bus.inst_valid);
      end
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         if (bus.inst_valid === 1'b1) found = 1;
      end
      n_cmp++;
      if (!found || bus.inst_pc !== 32'h100 || bus.inst_out !== mem_word(32'h100)) begin
         n_fail++;
         $display("FAIL rw_next_head: got found=%b pc=%h inst=%h want pc=00000100 inst=%h",
                  found, bus.inst_pc, bus.inst_out, mem_word(32'h100));
      end
   endtask

   task automatic test_redirect_valid_deq();
      bit found = 0;
      lat = 2;
      rdy_pct = 100;
      do_reset();
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (bus.imem_valid === 1'b1 && bus.inst_valid === 1'b1) found = 1;
      end
      n_cmp++;
      if (!found) begin
         n_fail++;
         $display("FAIL rv_setup: got no response with queue non-empty want one within 200 cycles");
      end
      bus.deq = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_0203;
      step();
      bus.redirect = 1'b0;
      bus.deq = 1'b0;
      n_cmp++;
      if (bus.inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rv_flush: got inst_valid=%b want 0", bus.inst_valid);
      end
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         if (e_acc) found = 1;
      end
      n_cmp++;
      if (!found || e_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL rv_next_addr: got found=%b addr=%h want 00000200", found, e_addr);
      end
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         if (bus.inst_valid === 1'b1) found = 1;
      end
      n_cmp++;
      if (!found || bus.inst_pc !== 32'h200) begin
         n_fail++;
         $display("FAIL rv_next_head: got found=%b pc=%h want 00000200", found, bus.inst_pc);
      end
   endtask

   task automatic test_redirect_req();
      bit found = 0;
      lat = 1;
      rdy_pct = 0;
      do_reset();
      step();
      step();
      n_cmp++;
      if (bus.imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rq_held: got req=%b want 1", bus.imem_req);
      end
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h340;
      step();
      bus.redirect = 1'b0;
      n_cmp++;
      if (bus.imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rq_retract: got req=%b want 0", bus.imem_req);
      end
      step();
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h340) begin
         n_fail++;
         $display("FAIL rq_restart: got req=%b addr=%h want req=1 addr=00000340", bus.imem_req, bus.imem_addr);
      end
      rdy_pct = 100;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         if (bus.inst_valid === 1'b1) found = 1;
      end
      n_cmp++;
      if (!found || bus.inst_pc !== 32'h340 || bus.inst_out !== mem_word(32'h340)) begin
         n_fail++;
         $display("FAIL rq_head: got found=%b pc=%h inst=%h want pc=00000340 inst=%h",
                  found, bus.inst_pc, bus.inst_out, mem_word(32'h340));
      end
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      lat = 3;
      rdy_pct = 100;
      do_reset();
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (mq.size() == 3 && m_out) found = 1;
      end
      n_cmp++;
      if (!found || bus.inst_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mr_setup: got found=%b inst_valid=%b want 1/1", found, bus.inst_valid);
      end
      reset = 1'b0;
      step();
      n_cmp++;
      if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL mr_cleared: got v=%b req=%b want 0/0", bus.inst_valid, bus.imem_req);
      end
      reset = 1'b1;
      step();
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
         n_fail++;
         $display("FAIL mr_restart: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
      end
   endtask

   task automatic test_random();
      int idle = 0;
      lat = 2;
      rdy_pct = 70;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            lat = int'($urandom_range(4, 1));
            rdy_pct = int'($urandom_range(100, 30));
         end
         step();
         n_cmp++;
         if (bus.inst_valid !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL rnd_valid @%0d: got %b want %b", i, bus.inst_valid, mq.size() != 0);
         end
         if (mq.size() != 0) begin
            n_cmp++;
            if (bus.inst_pc !== mq[0].pc || bus.inst_out !== mq[0].inst) begin
               n_fail++;
               $display("FAIL rnd_head @%0d: got pc=%h inst=%h want pc=%h inst=%h",
                        i, bus.inst_pc, bus.inst_out, mq[0].pc, mq[0].inst);
            end
         end
         if (e_acc) begin
            n_cmp++;
            if (e_addr !== e_exp) begin
               n_fail++;
               $display("FAIL rnd_req_addr @%0d: got %h want %h", i, e_addr, e_exp);
            end
         end
         n_cmp++;
         if (e_issue_bad || e_hold_bad) begin
            n_fail++;
            $display("FAIL rnd_protocol @%0d: got issue_bad=%b hold_bad=%b want 0/0", i, e_issue_bad, e_hold_bad);
         end
         if (e_rst && !m_out && mq.size() < DEPTH && bus.imem_req !== 1'b1) idle++;
         else idle = 0;
         if (idle == 4) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rnd_stall @%0d: got no request for %0d cycles want <=3", i, idle);
         end
         reset = ($urandom_range(149) != 0);
         bus.deq = $urandom_range(1);
         bus.redirect = ($urandom_range(19) == 0);
         bus.redirect_pc = $urandom;
      end
   endtask

   initial begin
      bus.imem_ready = 1'b1;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = '0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.deq = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_redirect_wait();
      test_redirect_valid_deq();
      test_redirect_req();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish by 1000000 want earlier finish");
      $fatal(1, "watchdog expired");
   end

endmodule
